// File: rtl/ctrl_pipe.sv
// ctrl_pipe: clocked 4-phase C-element micropipeline, DEPTH stages of WIDTH-bit data.
// Ports: clk, rst (async low), req_in/data_in/ack_in upstream, req_out/data_out/ack_out downstream, ctrl_out, busy.
module ctrl_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_in,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_out,
  output logic [DEPTH-1:0] ctrl_out,
  output logic             busy
);

  logic [DEPTH-1:0] ctrl_q;
  logic [DEPTH-1:0] a;
  logic [DEPTH-1:0] b;
  logic [DEPTH-1:0] ctrl_d;
  logic [DEPTH-1:0] rise;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] src    [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a[k]   = req_in;
      assign src[k] = data_in;
    end else begin : g_body
      assign a[k]   = ctrl_q[k-1];
      assign src[k] = data_q[k-1];
    end
    if (k == DEPTH - 1) begin : g_tail
      assign b[k] = ~ack_out;
    end else begin : g_next
      assign b[k] = ~ctrl_q[k+1];
    end
  end

  // Majority of (a, b, ctrl): set on 11, clear on 00, hold otherwise.
  assign ctrl_d = (a & b) | (ctrl_q & (a | b));
  assign rise   = ctrl_d & ~ctrl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      ctrl_q <= ctrl_d;
      // Data moves only with the rising phase of a token.
      for (int k = 0; k < DEPTH; k++) begin
        if (rise[k]) begin
          data_q[k] <= src[k];
        end
      end
    end
  end

  assign ack_in   = ctrl_q[0];
  assign req_out  = ctrl_q[DEPTH-1];
  assign data_out = data_q[DEPTH-1];
  assign ctrl_out = ctrl_q;
  assign busy     = |ctrl_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe (DEPTH=4 main instance, DEPTH=1 legacy instance).
// Tasks per scenario check outputs #1 after the rising edge.
module tb_ctrl_pipe;

  logic       clk;
  logic       rst;
  logic       req_in;
  logic [7:0] data_in;
  logic       ack_in;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_out;
  logic [3:0] ctrl_out;
  logic       busy;

  logic       req1;
  logic [7:0] din1;
  logic       ack_in1;
  logic       req_out1;
  logic [7:0] dout1;
  logic       ack1;
  logic [0:0] ctrl1;
  logic       busy1;

  int checks;
  int failures;

  ctrl_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .data_in(data_in), .ack_in(ack_in),
    .req_out(req_out), .data_out(data_out), .ack_out(ack_out),
    .ctrl_out(ctrl_out), .busy(busy)
  );

  ctrl_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_in(req1), .data_in(din1), .ack_in(ack_in1),
    .req_out(req_out1), .data_out(dout1), .ack_out(ack1),
    .ctrl_out(ctrl1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input logic [7:0] d, input int budget,
                           output bit acked);
    int n;
    req_in  = 1'b1;
    data_in = d;
    acked   = 1'b0;
    n = 0;
    while (!acked && n < budget) begin
      tick();
      n++;
      if (ack_in) acked = 1'b1;
    end
    if (acked) begin
      req_in = 1'b0;
      n = 0;
      while (ack_in && n < budget) begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_in = 1'b1; ack_out = 1'b1; data_in = 8'hFF;
    req1 = 1'b1; ack1 = 1'b1; din1 = 8'hFF;
    #1;
    checks++;
    if ({ctrl_out, req_out, ack_in, data_out, busy} !== 15'h0) begin
      failures++;
      $display("FAIL reset_main got ctrl=%b req=%b ack=%b data=%h busy=%b exp all 0",
               ctrl_out, req_out, ack_in, data_out, busy);
    end
    checks++;
    if ({ctrl1, req_out1, ack_in1, dout1, busy1} !== 12'h0) begin
      failures++;
      $display("FAIL reset_d1 got ctrl=%b data=%h exp 0", ctrl1, dout1);
    end
    req_in = 1'b0; ack_out = 1'b0; req1 = 1'b0; ack1 = 1'b0;
    #2 rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ctrl_out !== 4'b0000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=0000", ctrl_out);
    end
  endtask

  task automatic test_single(input logic [7:0] d, input string tag);
    logic [3:0] fill [4];
    logic [3:0] drain [4];
    fill  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    drain = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    req_in = 1'b1; data_in = d; ack_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ctrl_out !== fill[i]) begin
        failures++;
        $display("FAIL %s_fill%0d got=%b exp=%b", tag, i, ctrl_out, fill[i]);
      end
    end
    checks++;
    if (req_out !== 1'b1 || data_out !== d) begin
      failures++;
      $display("FAIL %s_out got req=%b data=%h exp req=1 data=%h",
               tag, req_out, data_out, d);
    end
    ack_out = 1'b1; req_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ctrl_out !== drain[i]) begin
        failures++;
        $display("FAIL %s_drain%0d got=%b exp=%b", tag, i, ctrl_out, drain[i]);
      end
    end
    ack_out = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || data_out !== d) begin
      failures++;
      $display("FAIL %s_idle got busy=%b data=%h exp busy=0 data=%h",
               tag, busy, data_out, d);
    end
  endtask

  task automatic test_stall();
    bit ok;
    push_item(8'h11, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_push11 got acked=0 exp acked=1");
    end
    push_item(8'h22, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_push22 got acked=0 exp acked=1");
    end
    push_item(8'h33, 8, ok);
    checks++;
    if (ok) begin
      failures++;
      $display("FAIL stall_push33 got acked=1 exp acked=0");
    end
    checks++;
    if (ctrl_out !== 4'b1010 || data_out !== 8'h11 || ack_in !== 1'b0) begin
      failures++;
      $display("FAIL stall_state got ctrl=%b data=%h ack=%b exp 1010 11 0",
               ctrl_out, data_out, ack_in);
    end
  endtask

  // Upstream still holds 8'h33 on req_in; it is accepted once space frees.
  task automatic test_drain();
    logic [7:0] got [3];
    bit up_to, dn_to;
    int n;
    up_to = 1'b0; dn_to = 1'b0;
    got = '{8'h00, 8'h00, 8'h00};
    fork
      begin
        int m;
        m = 0;
        while (!ack_in && m < 40) begin tick(); m++; end
        if (!ack_in) up_to = 1'b1;
        req_in = 1'b0;
        m = 0;
        while (ack_in && m < 40) begin tick(); m++; end
        if (ack_in) up_to = 1'b1;
      end
      begin
        int m;
        for (int i = 0; i < 3; i++) begin
          m = 0;
          while (!req_out && m < 40) begin tick(); m++; end
          if (!req_out) dn_to = 1'b1;
          got[i] = data_out;
          ack_out = 1'b1;
          m = 0;
          while (req_out && m < 40) begin tick(); m++; end
          if (req_out) dn_to = 1'b1;
          ack_out = 1'b0;
        end
      end
    join
    checks++;
    if (up_to || dn_to) begin
      failures++;
      $display("FAIL drain_timeout got up=%b dn=%b exp 0 0", up_to, dn_to);
    end
    checks++;
    if (got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      failures++;
      $display("FAIL drain_order got=%h,%h,%h exp=11,22,33",
               got[0], got[1], got[2]);
    end
    n = 0;
    while (n < 6) begin tick(); n++; end
    checks++;
    if (ctrl_out !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty got ctrl=%b busy=%b exp 0000 0", ctrl_out, busy);
    end
  endtask

  task automatic test_reset_mid();
    req_in = 1'b1; data_in = 8'h77;
    tick();
    req_in = 1'b0;
    tick();
    tick();
    checks++;
    if (ctrl_out !== 4'b0110) begin
      failures++;
      $display("FAIL mid_setup got=%b exp=0110", ctrl_out);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ctrl_out !== 4'b0000 || data_out !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got ctrl=%b data=%h busy=%b exp 0000 00 0",
               ctrl_out, data_out, busy);
    end
    #2 rst = 1'b1;
    tick();
    test_single(8'h5A, "post_reset");
  endtask

  task automatic test_depth1();
    req1 = 1'b1; din1 = 8'h3C; ack1 = 1'b0;
    tick();
    checks++;
    if (ack_in1 !== 1'b1 || req_out1 !== 1'b1 || dout1 !== 8'h3C) begin
      failures++;
      $display("FAIL d1_set got ack=%b req=%b data=%h exp 1 1 3c",
               ack_in1, req_out1, dout1);
    end
    ack1 = 1'b1;
    tick();
    checks++;
    if (ctrl1 !== 1'b1) begin
      failures++;
      $display("FAIL d1_hold got=%b exp=1", ctrl1);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (ctrl1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL d1_clear got ctrl=%b busy=%b exp 0 0", ctrl1, busy1);
    end
    ack1 = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single(8'hA5, "single");
    test_stall();
    test_drain();
    test_reset_mid();
    test_depth1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
